// File: rtl/pipeline_run_controller_pkg.sv
// Shared types and constants for the pipeline run controller.
package pipeline_run_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STEP_WAIT = 3'd2,
    ST_STEP      = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_DONE      = 3'd5
  } run_state_e;

  localparam logic [31:0] HALT_WORD_DEFAULT    = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD             = 32'h0000_0000;
  localparam int          DRAIN_CYCLES_DEFAULT = 4;

  // States in which the pipeline registers are clocked.
  function automatic logic state_clocks_pipe(run_state_e s);
    return (s == ST_RUN) || (s == ST_STEP) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/pipeline_run_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_run_controller.sv
// Run/step/halt sequencer for the 5-stage pipeline: gates the global enable,
// drains in-flight instructions after HALT or stop, and counts enabled cycles.
//
//   state      | meaning
//   IDLE       | after reset, waiting for start
//   RUN        | continuous execution
//   STEP_WAIT  | step mode, pipeline frozen until stepReq
//   STEP       | one enabled cycle in step mode
//   DRAIN      | fetch stopped, retiring in-flight instructions
//   DONE       | halted, capture registers valid
module pipeline_run_controller
  import pipeline_run_controller_pkg::*;
#(
  parameter logic [31:0] HALT_WORD    = HALT_WORD_DEFAULT,
  parameter int          DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
  parameter int          CNT_W        = 32
) (
  input  logic             clock,
  input  logic             resetGral,
  input  logic             start,
  input  logic             stepMode,
  input  logic             stepReq,
  input  logic             stopReq,
  input  logic [31:0]      instruction,
  input  logic [7:0]       pcFE,
  output logic             pipeEnable,
  output logic             fetchEnable,
  output logic             running,
  output logic             halted,
  output logic             haltByInstr,
  output logic [7:0]       haltPc,
  output logic [CNT_W-1:0] cycleCount,
  output logic [2:0]       state
);

  localparam int            DRAIN_W    = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);

  run_state_e         state_q;
  logic [DRAIN_W-1:0] drain_cnt_q;
  logic [7:0]         halt_pc_q;
  logic               halt_by_instr_q;

  logic halt_fetched;
  logic start_accept;

  assign halt_fetched = (instruction == HALT_WORD);
  assign start_accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_ff @(posedge clock or negedge resetGral) begin
    if (!resetGral) begin
      state_q         <= ST_IDLE;
      drain_cnt_q     <= '0;
      halt_pc_q       <= '0;
      halt_by_instr_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q         <= stepMode ? ST_STEP_WAIT : ST_RUN;
            halt_pc_q       <= '0;
            halt_by_instr_q <= 1'b0;
          end
        end
        // HALT outranks an external stop arriving on the same cycle.
        ST_RUN: begin
          if (halt_fetched) begin
            state_q         <= ST_DRAIN;
            halt_pc_q       <= pcFE;
            halt_by_instr_q <= 1'b1;
            drain_cnt_q     <= DRAIN_LOAD;
          end else if (stopReq) begin
            state_q         <= ST_DRAIN;
            halt_pc_q       <= pcFE;
            halt_by_instr_q <= 1'b0;
            drain_cnt_q     <= DRAIN_LOAD;
          end
        end
        ST_STEP_WAIT: begin
          if (stopReq) begin
            state_q         <= ST_DRAIN;
            halt_pc_q       <= pcFE;
            halt_by_instr_q <= 1'b0;
            drain_cnt_q     <= DRAIN_LOAD;
          end else if (stepReq) begin
            state_q <= ST_STEP;
          end else if (!stepMode) begin
            state_q <= ST_RUN;
          end
        end
        ST_STEP: begin
          if (halt_fetched) begin
            state_q         <= ST_DRAIN;
            halt_pc_q       <= pcFE;
            halt_by_instr_q <= 1'b1;
            drain_cnt_q     <= DRAIN_LOAD;
          end else begin
            state_q <= ST_STEP_WAIT;
          end
        end
        // Loaded with DRAIN_CYCLES on entry, so exiting at 1 gives exactly that many cycles.
        ST_DRAIN: begin
          drain_cnt_q <= drain_cnt_q - DRAIN_W'(1);
          if (drain_cnt_q == DRAIN_W'(1)) begin
            state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_cycle_cnt (
    .clk_i   (clock),
    .rst_ni  (resetGral),
    .clr_i   (start_accept),
    .en_i    (pipeEnable),
    .count_o (cycleCount)
  );

  assign pipeEnable  = state_clocks_pipe(state_q);
  assign fetchEnable = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !halt_fetched;
  assign running     = (state_q == ST_RUN) || (state_q == ST_STEP_WAIT) ||
                       (state_q == ST_STEP) || (state_q == ST_DRAIN);
  assign halted      = (state_q == ST_DONE);
  assign haltByInstr = halt_by_instr_q;
  assign haltPc      = halt_pc_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Bench for pipeline_run_controller: directed scenarios checked every cycle
// against a behavioural model, plus hand-computed literal expectations.
module tb_pipeline_run_controller;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] NORM = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        resetGral = 1'b0;
  logic        start = 1'b0, stepMode = 1'b0, stepReq = 1'b0, stopReq = 1'b0;
  logic [31:0] instruction = NORM;
  logic [7:0]  pcFE = 8'h00;

  logic        pipeEnable, fetchEnable, running, halted, haltByInstr;
  logic [7:0]  haltPc;
  logic [31:0] cycleCount;
  logic [2:0]  state;

  logic        pipeEnable4, fetchEnable4, running4, halted4, haltByInstr4;
  logic [7:0]  haltPc4;
  logic [3:0]  cycleCount4;
  logic [2:0]  state4;

  pipeline_run_controller #(.CNT_W(32)) dut (
    .clock(clock), .resetGral(resetGral), .start(start), .stepMode(stepMode),
    .stepReq(stepReq), .stopReq(stopReq), .instruction(instruction), .pcFE(pcFE),
    .pipeEnable(pipeEnable), .fetchEnable(fetchEnable), .running(running),
    .halted(halted), .haltByInstr(haltByInstr), .haltPc(haltPc),
    .cycleCount(cycleCount), .state(state)
  );

  pipeline_run_controller #(.CNT_W(4)) dut4 (
    .clock(clock), .resetGral(resetGral), .start(start), .stepMode(stepMode),
    .stepReq(stepReq), .stopReq(stopReq), .instruction(instruction), .pcFE(pcFE),
    .pipeEnable(pipeEnable4), .fetchEnable(fetchEnable4), .running(running4),
    .halted(halted4), .haltByInstr(haltByInstr4), .haltPc(haltPc4),
    .cycleCount(cycleCount4), .state(state4)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode codes 0..5 = IDLE, RUN, STEP_WAIT, STEP, DRAIN, DONE.
  int     m_state = 0;
  int     m_left  = 0;
  longint m_cnt   = 0;
  longint m_cnt4  = 0;
  int     m_pc    = 0;
  bit     m_hbi   = 1'b0;

  always @(posedge clock or negedge resetGral) begin : model
    bit clocked;
    bit is_halt;
    if (!resetGral) begin
      m_state = 0; m_left = 0; m_cnt = 0; m_cnt4 = 0; m_pc = 0; m_hbi = 1'b0;
    end else begin
      clocked = (m_state == 1) || (m_state == 3) || (m_state == 4);
      is_halt = (instruction == HALT);
      if (clocked) begin
        if (m_cnt < 64'h0000_0000_FFFF_FFFF) m_cnt = m_cnt + 1;
        if (m_cnt4 < 15) m_cnt4 = m_cnt4 + 1;
      end
      case (m_state)
        0, 5: if (start) begin
          m_cnt = 0; m_cnt4 = 0; m_pc = 0; m_hbi = 1'b0;
          m_state = stepMode ? 2 : 1;
        end
        1: if (is_halt) begin
          m_pc = pcFE; m_hbi = 1'b1; m_left = 4; m_state = 4;
        end else if (stopReq) begin
          m_pc = pcFE; m_hbi = 1'b0; m_left = 4; m_state = 4;
        end
        2: if (stopReq) begin
          m_pc = pcFE; m_hbi = 1'b0; m_left = 4; m_state = 4;
        end else if (stepReq) m_state = 3;
        else if (!stepMode) m_state = 1;
        3: if (is_halt) begin
          m_pc = pcFE; m_hbi = 1'b1; m_left = 4; m_state = 4;
        end else m_state = 2;
        4: begin
          m_left = m_left - 1;
          if (m_left == 0) m_state = 5;
        end
        default: m_state = 0;
      endcase
    end
  end

  bit count_pe = 1'b0;
  int pe_pulses = 0;

  always @(negedge clock) begin : compare
    int es;
    es = m_state;
    chk("state", state, es);
    chk("pipeEnable", pipeEnable, (es == 1) || (es == 3) || (es == 4));
    chk("fetchEnable", fetchEnable, ((es == 1) || (es == 3)) && (instruction != HALT));
    chk("running", running, (es >= 1) && (es <= 4));
    chk("halted", halted, es == 5);
    chk("haltByInstr", haltByInstr, m_hbi);
    chk("haltPc", haltPc, m_pc);
    chk("cycleCount", cycleCount, m_cnt);
    chk("state_w4", state4, es);
    chk("cycleCount_w4", cycleCount4, m_cnt4);
    if (count_pe && pipeEnable) pe_pulses++;
  end

  task automatic tick(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(bit step_mode);
    stepMode = step_mode;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state, then async reset in the middle of RUN
    #12 resetGral = 1'b1;
    tick(1);
    chk("t1_idle_state", state, 0);
    chk("t1_idle_pe", pipeEnable, 0);
    pulse_start(1'b0);
    chk("t1_run_state", state, 1);
    tick(3);
    resetGral = 1'b0;
    #1;
    chk("t1_rst_state", state, 0);
    chk("t1_rst_pe", pipeEnable, 0);
    chk("t1_rst_cnt", cycleCount, 0);
    chk("t1_rst_halted", halted, 0);
    #2 resetGral = 1'b1;
    tick(1);

    // 2: HALT on the 10th enabled cycle; inputs during DRAIN are ignored
    pulse_start(1'b0);
    pcFE = 8'h01;
    tick(9);
    instruction = HALT; pcFE = 8'h07;
    #1;
    chk("t2_fetch_off", fetchEnable, 0);
    chk("t2_pe_on", pipeEnable, 1);
    tick(1);
    instruction = NORM; pcFE = 8'h08;
    chk("t2_drain", state, 4);
    start = 1'b1; stopReq = 1'b1; stepReq = 1'b1;
    tick(1);
    start = 1'b0; stopReq = 1'b0; stepReq = 1'b0;
    chk("t2_drain_ignores", state, 4);
    tick(3);
    chk("t2_halted", halted, 1);
    chk("t2_haltPc", haltPc, 8'h07);
    chk("t2_hbi", haltByInstr, 1);
    chk("t2_cnt", cycleCount, 14);

    // 3: three single steps, 3 cycles apart
    pulse_start(1'b1);
    chk("t3_wait", state, 2);
    pe_pulses = 0;
    count_pe = 1'b1;
    for (int k = 0; k < 3; k++) begin
      stepReq = 1'b1;
      tick(1);
      stepReq = 1'b0;
      chk("t3_step", state, 3);
      tick(1);
      chk("t3_back", state, 2);
      tick(1);
    end
    count_pe = 1'b0;
    chk("t3_pulses", pe_pulses, 3);
    chk("t3_cnt", cycleCount, 3);
    stepMode = 1'b0;
    tick(1);
    chk("t3_to_run", state, 1);

    // 4: external stop in RUN
    tick(2);
    stopReq = 1'b1; pcFE = 8'h20;
    tick(1);
    stopReq = 1'b0; pcFE = 8'h21;
    chk("t4_drain", state, 4);
    tick(4);
    chk("t4_done", state, 5);
    chk("t4_haltPc", haltPc, 8'h20);
    chk("t4_hbi", haltByInstr, 0);

    // 5a: HALT and stop together -> HALT wins
    pulse_start(1'b0);
    tick(2);
    instruction = HALT; stopReq = 1'b1; pcFE = 8'h33;
    tick(1);
    instruction = NORM; stopReq = 1'b0;
    chk("t5a_hbi", haltByInstr, 1);
    chk("t5a_haltPc", haltPc, 8'h33);
    tick(4);
    chk("t5a_done", state, 5);

    // 5b: stepReq with stopReq in STEP_WAIT -> DRAIN, no STEP
    pulse_start(1'b1);
    stepReq = 1'b1; stopReq = 1'b1; pcFE = 8'h44;
    tick(1);
    stepReq = 1'b0; stopReq = 1'b0;
    chk("t5b_drain", state, 4);
    chk("t5b_hbi", haltByInstr, 0);
    chk("t5b_haltPc", haltPc, 8'h44);
    tick(4);
    chk("t5b_done", state, 5);

    // 5c: HALT fetched during a STEP cycle
    pulse_start(1'b1);
    stepReq = 1'b1;
    tick(1);
    instruction = HALT; pcFE = 8'h55;
    #1;
    chk("t5c_step", state, 3);
    chk("t5c_fetch_off", fetchEnable, 0);
    tick(1);
    instruction = NORM; stepReq = 1'b0;
    chk("t5c_drain", state, 4);
    chk("t5c_hbi", haltByInstr, 1);
    tick(4);
    chk("t5c_done", state, 5);
    chk("t5c_haltPc", haltPc, 8'h55);

    // 6: saturation of the narrow counter, then restart from DONE clears
    pulse_start(1'b0);
    tick(20);
    chk("t6_cnt32", cycleCount, 20);
    chk("t6_cnt4_sat", cycleCount4, 4'hF);
    stopReq = 1'b1; pcFE = 8'h66;
    tick(1);
    stopReq = 1'b0;
    tick(4);
    chk("t6_done", state, 5);
    chk("t6_cnt32_done", cycleCount, 25);
    chk("t6_haltPc", haltPc, 8'h66);
    pulse_start(1'b0);
    chk("t6_clr_cnt", cycleCount, 0);
    chk("t6_clr_cnt4", cycleCount4, 0);
    chk("t6_clr_pc", haltPc, 0);
    tick(2);
    chk("t6_recount", cycleCount, 2);

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
